// File: rtl/oib_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : oib_pkg                                                         |
// | Purpose  : Shared constants, FSM encodings and parity helper for the       |
// |            off-chip byte bus arbiter.                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package oib_pkg;

    localparam int         c_BUS_W   = 8;
    localparam int         c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_S_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0] c_S_SEND = 2'd1;
    localparam logic [c_STATE_W-1:0] c_S_RESP = 2'd2;

    function automatic logic oib_parity(input logic [c_BUS_W-1:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oib_phase_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : oib_phase_gen                                                   |
// | Purpose  : Byte-period phase counter and registered bus clock, with        |
// |            hold/clear controls and sample/end-of-period strobes.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module oib_phase_gen #(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_hold,
    output logic o_oib_clk,
    output logic o_sample,
    output logic o_period_end
);

    localparam int              c_PH_W    = $clog2(2 * HALF_DIV);
    localparam logic [c_PH_W-1:0] c_PH_MAX  = c_PH_W'(2 * HALF_DIV - 1);
    localparam logic [c_PH_W-1:0] c_PH_HALF = c_PH_W'(HALF_DIV);

    logic [c_PH_W-1:0] r_ph;
    logic [c_PH_W-1:0] w_ph_next;
    logic              r_oib_clk;

    always_comb begin
        w_ph_next = r_ph;
        if (i_clear) begin
            w_ph_next = '0;
        end else if (!i_hold) begin
            w_ph_next = (r_ph == c_PH_MAX) ? '0 : r_ph + 1'b1;
        end
    end

    // Bus clock is derived from the next phase so it stays aligned with r_ph.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ph      <= '0;
            r_oib_clk <= 1'b0;
        end else begin
            r_ph      <= w_ph_next;
            r_oib_clk <= (w_ph_next >= c_PH_HALF);
        end
    end

    assign o_oib_clk    = r_oib_clk;
    assign o_sample     = (r_ph == c_PH_HALF);
    assign o_period_end = (r_ph == c_PH_MAX);

endmodule
`default_nettype wire

// File: rtl/oib_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : oib_bus_arbiter                                                 |
// | Purpose  : Round-robin, packet-granular owner of the off-chip byte bus.    |
// |            Optional stall abort enabled by `OIB_TIMEOUT_EN.                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module oib_bus_arbiter
    import oib_pkg::*;
#(
    parameter int HALF_DIV    = 2,
    parameter int RESP_BYTES  = 4,
    parameter int PARITY_ODD  = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        ext_clk,
    input  logic        ext_rst_n,
    input  logic [1:0]  rq_valid,
    input  logic [15:0] rq_data,
    input  logic [1:0]  rq_last,
    output logic [1:0]  rq_ready,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_perr,
    output logic [1:0]  grant,
    output logic        timeout,
    output logic        oib_clk,
    output logic [7:0]  ob_data,
    output logic        ob_pty,
    input  logic [7:0]  ib_data,
    input  logic        ib_pty
);

    localparam logic             c_ODD      = (PARITY_ODD != 0);
    localparam logic             c_HAS_RESP = (RESP_BYTES > 0);
    localparam int               c_RCW      = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;
    localparam logic [c_RCW-1:0] c_RSP_LAST = c_RCW'((RESP_BYTES > 0) ? RESP_BYTES - 1 : 0);

    if (HALF_DIV < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("oib_bus_arbiter: HALF_DIV and TIMEOUT_CYC must be >= 1");
    end

    logic [c_STATE_W-1:0] r_state, w_state_next;
    logic [1:0]           r_grant;
    logic                 r_rr_ptr;
    logic                 r_last;
    logic [c_BUS_W-1:0]   r_ob_data;
    logic                 r_ob_pty;
    logic [1:0]           r_rsp_valid;
    logic [c_BUS_W-1:0]   r_rsp_data;
    logic                 r_rsp_perr;
    logic [c_RCW-1:0]     r_rsp_cnt;

    logic                 w_sel, w_owner, w_own_valid, w_own_last;
    logic [c_BUS_W-1:0]   w_own_byte;
    logic [1:0]           w_rq_ready;
    logic                 w_accept, w_hold, w_clear, w_abort, w_resp_done;
    logic                 w_sample, w_period_end, w_oib_clk;

    // In IDLE the owner is the arbitration winner; during a packet it is the latched grant.
    assign w_sel       = rq_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
    assign w_owner     = (r_state == c_S_IDLE) ? w_sel : r_grant[1];
    assign w_own_valid = rq_valid[w_owner];
    assign w_own_last  = rq_last[w_owner];
    assign w_own_byte  = w_owner ? rq_data[15:8] : rq_data[7:0];
    assign w_resp_done = w_period_end && (r_rsp_cnt == c_RSP_LAST);
    assign w_accept    = |(w_rq_ready & rq_valid);
    assign w_clear     = (r_state == c_S_IDLE) || (w_state_next == c_S_IDLE);

    oib_phase_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_phase (
        .clk          (ext_clk),
        .rst_n        (ext_rst_n),
        .i_clear      (w_clear),
        .i_hold       (w_hold),
        .o_oib_clk    (w_oib_clk),
        .o_sample     (w_sample),
        .o_period_end (w_period_end)
    );

    always_ff @(posedge ext_clk) begin
        if (!ext_rst_n) r_state <= c_S_IDLE;
        else            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (w_own_valid) w_state_next = c_S_SEND;
            c_S_SEND: begin
                if (w_abort)
                    w_state_next = c_S_IDLE;
                else if (w_period_end && r_last)
                    w_state_next = c_HAS_RESP ? c_S_RESP : c_S_IDLE;
            end
            c_S_RESP: if (w_resp_done) w_state_next = c_S_IDLE;
            default:  w_state_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_rq_ready = 2'b00;
        w_hold     = 1'b0;
        case (r_state)
            c_S_IDLE: if (w_own_valid) w_rq_ready[w_owner] = 1'b1;
            c_S_SEND: begin
                if (w_period_end && !r_last) begin
                    w_rq_ready[w_owner] = 1'b1;
                    w_hold              = !w_own_valid;
                end
            end
            default: ;
        endcase
    end

`ifdef OIB_TIMEOUT_EN
    localparam int               c_TOW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TOW-1:0] c_TO_LAST = c_TOW'(TIMEOUT_CYC - 1);

    logic [c_TOW-1:0] r_stall_cnt;
    logic             r_timeout;

    assign w_abort = w_hold && (r_stall_cnt == c_TO_LAST);

    always_ff @(posedge ext_clk) begin
        if (!ext_rst_n) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_stall_cnt <= (w_hold && !w_abort) ? r_stall_cnt + 1'b1 : '0;
            r_timeout   <= w_abort;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_abort = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge ext_clk) begin
        if (!ext_rst_n) begin
            r_ob_data   <= '0;
            r_ob_pty    <= c_ODD;
            r_last      <= 1'b0;
            r_grant     <= 2'b00;
            r_rr_ptr    <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= '0;
            r_rsp_perr  <= 1'b0;
            r_rsp_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_ob_data <= w_own_byte;
                r_ob_pty  <= oib_parity(w_own_byte, c_ODD);
                r_last    <= w_own_last;
            end else if (w_state_next != c_S_SEND) begin
                r_ob_data <= '0;
                r_ob_pty  <= c_ODD;
                r_last    <= 1'b0;
            end

            if (r_state == c_S_IDLE) begin
                r_grant <= w_accept ? (w_owner ? 2'b10 : 2'b01) : 2'b00;
            end else if (w_state_next == c_S_IDLE) begin
                r_grant  <= 2'b00;
                r_rr_ptr <= ~r_grant[1];
            end

            if (r_state == c_S_RESP && w_sample) begin
                r_rsp_valid <= r_grant;
                r_rsp_data  <= ib_data;
                r_rsp_perr  <= (oib_parity(ib_data, c_ODD) != ib_pty);
            end else begin
                r_rsp_valid <= 2'b00;
            end

            if (r_state == c_S_RESP && w_period_end)
                r_rsp_cnt <= w_resp_done ? '0 : r_rsp_cnt + 1'b1;
            else if (r_state != c_S_RESP)
                r_rsp_cnt <= '0;
        end
    end

    assign rq_ready  = w_rq_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_perr  = r_rsp_perr;
    assign grant     = r_grant;
    assign oib_clk   = w_oib_clk;
    assign ob_data   = r_ob_data;
    assign ob_pty    = r_ob_pty;

endmodule
`default_nettype wire

// File: tb/tb_oib_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_oib_bus_arbiter                                              |
// | Purpose  : Directed self-checking bench for oib_bus_arbiter                |
// |            (HALF_DIV=2, RESP_BYTES=4, even parity, TIMEOUT_CYC=16).        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_oib_bus_arbiter;

    logic        ext_clk = 1'b0;
    logic        ext_rst_n;
    logic [1:0]  rq_valid;
    logic [15:0] rq_data;
    logic [1:0]  rq_last;
    logic [1:0]  rq_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_perr;
    logic [1:0]  grant;
    logic        timeout;
    logic        oib_clk;
    logic [7:0]  ob_data;
    logic        ob_pty;
    logic [7:0]  ib_data;
    logic        ib_pty;

    int checks = 0;
    int errors = 0;

    oib_bus_arbiter #(
        .HALF_DIV    (2),
        .RESP_BYTES  (4),
        .PARITY_ODD  (0),
        .TIMEOUT_CYC (16)
    ) dut (
        .ext_clk   (ext_clk),
        .ext_rst_n (ext_rst_n),
        .rq_valid  (rq_valid),
        .rq_data   (rq_data),
        .rq_last   (rq_last),
        .rq_ready  (rq_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_perr  (rsp_perr),
        .grant     (grant),
        .timeout   (timeout),
        .oib_clk   (oib_clk),
        .ob_data   (ob_data),
        .ob_pty    (ob_pty),
        .ib_data   (ib_data),
        .ib_pty    (ib_pty)
    );

    always #5 ext_clk = ~ext_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ext_clk);
        #1;
    endtask

    task automatic do_reset();
        ext_rst_n = 1'b0;
        rq_valid  = 2'b00;
        rq_data   = 16'h0000;
        rq_last   = 2'b00;
        ib_data   = 8'h00;
        ib_pty    = 1'b0;
        repeat (3) tick();
        ext_rst_n = 1'b1;
    endtask

    // Runs the remainder of a packet; the responder returns 0x01..0x04 with
    // parity corrupted on response index 'bad' (-1 for none).
    task automatic finish_pkt(input string tag, input logic [1:0] own, input int bad);
        int k = 0;
        bit done = 0;
        ib_data = 8'h01;
        ib_pty  = 1'b1 ^ (bad == 0);
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (rsp_valid != 2'b00) begin
                check({tag, "_rv"}, 32'(rsp_valid), 32'(own));
                check({tag, "_rd"}, 32'(rsp_data), 32'(k + 1));
                check({tag, "_pe"}, 32'(rsp_perr), 32'(k == bad));
                k++;
                ib_data = 8'(k + 1);
                ib_pty  = (^ib_data) ^ (k == bad);
            end
            if (grant == 2'b00) done = 1;
        end
        check({tag, "_nrsp"}, 32'(k), 32'd4);
        check({tag, "_idle"}, {29'd0, oib_clk, grant}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ob", {23'd0, ob_pty, ob_data}, 32'd0);
        check("rst_misc", {27'd0, oib_clk, timeout, rsp_valid, rsp_perr}, 32'd0);
        check("rst_ready", 32'(rq_ready), 32'd0);

        // req0 sends A5, 3C(last)
        rq_valid = 2'b01; rq_data = 16'h00A5; rq_last = 2'b00;
        #1 check("p1_rdy_idle", 32'(rq_ready), 32'h1);
        tick();
        check("p1_b0", {23'd0, ob_pty, ob_data}, 32'h0A5);
        check("p1_grant", 32'(grant), 32'h1);
        check("p1_clk_lo", 32'(oib_clk), 32'd0);
        check("p1_rdy_mid", 32'(rq_ready), 32'd0);
        rq_data = 16'h003C; rq_last = 2'b01;
        tick(); tick();
        check("p1_clk_hi", {23'd0, oib_clk, ob_data}, 32'h1A5);
        tick();
        check("p1_rdy_end", 32'(rq_ready), 32'h1);
        tick();
        check("p1_b1", {23'd0, ob_pty, ob_data}, 32'h03C);
        check("p1_b1_clk", 32'(oib_clk), 32'd0);
        rq_valid = 2'b00;
        tick(); tick(); tick();
        check("p1_b1_hold", {23'd0, oib_clk, ob_data}, 32'h13C);
        check("p1_rdy_last", 32'(rq_ready), 32'd0);
        tick();
        check("p1_resp_ob", {23'd0, ob_pty, ob_data}, 32'd0);
        finish_pkt("p1", 2'b01, -1);

        // Round-robin alternation with both requesters valid after reset
        do_reset();
        rq_valid = 2'b11; rq_data = 16'h2211; rq_last = 2'b11;
        #1 check("alt_rdy0", 32'(rq_ready), 32'h1);
        tick();
        check("alt_g0", {22'd0, grant, ob_data}, 32'h111);
        check("alt_ignore", 32'(rq_ready), 32'd0);
        finish_pkt("alt0", 2'b01, -1);
        check("alt_rdy1", 32'(rq_ready), 32'h2);
        tick();
        check("alt_g1", {22'd0, grant, ob_data}, 32'h222);
        finish_pkt("alt1", 2'b10, -1);
        check("alt_rdy2", 32'(rq_ready), 32'h1);
        tick();
        check("alt_g2", 32'(grant), 32'h1);
        rq_valid = 2'b00;
        finish_pkt("alt2", 2'b01, -1);

        // Inbound parity error on second response byte
        rq_valid = 2'b10; rq_data = 16'h8000; rq_last = 2'b10;
        #1 check("pe_rdy", 32'(rq_ready), 32'h2);
        tick();
        check("pe_ob", {23'd0, ob_pty, ob_data}, 32'h180);
        rq_valid = 2'b00;
        finish_pkt("perr", 2'b10, 1);

        // req0 stalls 10 cycles mid-packet
        rq_valid = 2'b01; rq_data = 16'h005A; rq_last = 2'b00;
        tick();
        check("st_b0", 32'(ob_data), 32'h5A);
        rq_valid = 2'b00;
        tick(); tick(); tick();
        check("st_rdy", 32'(rq_ready), 32'h1);
        for (int i = 0; i < 10; i++) begin
            check("st_hold", {22'd0, oib_clk, ob_data, timeout}, {22'd0, 1'b1, 8'h5A, 1'b0});
            tick();
        end
        rq_valid = 2'b01; rq_data = 16'h000F; rq_last = 2'b01;
        #1 check("st_rdy_resume", 32'(rq_ready), 32'h1);
        tick();
        check("st_b1", {23'd0, oib_clk, ob_data}, 32'h00F);
        rq_valid = 2'b00;
        finish_pkt("stall", 2'b01, -1);

        // Reset asserted during RESP (rr_ptr currently points at req1)
        rq_valid = 2'b01; rq_data = 16'h0044; rq_last = 2'b01;
        tick();
        rq_valid = 2'b00;
        repeat (6) tick();
        ext_rst_n = 1'b0;
        rq_valid = 2'b11; rq_data = 16'h3344; rq_last = 2'b11;
        tick();
        check("rr_grant", 32'(grant), 32'd0);
        check("rr_ob", {23'd0, ob_pty, ob_data}, 32'd0);
        check("rr_misc", {27'd0, oib_clk, timeout, rsp_valid, rsp_perr}, 32'd0);
        ext_rst_n = 1'b1;
        #1 check("rr_rdy", 32'(rq_ready), 32'h1);
        tick();
        check("rr_g", 32'(grant), 32'h1);
        rq_valid = 2'b00;
        finish_pkt("post_rst", 2'b01, -1);

        // req1 stalls indefinitely
        rq_valid = 2'b10; rq_data = 16'h1100; rq_last = 2'b00;
        tick();
        rq_valid = 2'b00;
`ifdef OIB_TIMEOUT_EN
        begin
            int n = 0;
            for (int c = 2; c <= 40; c++) begin
                tick();
                if (timeout) begin
                    n = c;
                    break;
                end
            end
            check("to_cycles", 32'(n), 32'd20);
            check("to_grant", 32'(grant), 32'd0);
            tick();
            check("to_pulse", 32'(timeout), 32'd0);
        end
`else
        begin
            int seen = 0;
            for (int c = 0; c < 30; c++) begin
                tick();
                if (timeout) seen++;
            end
            check("noto_seen", 32'(seen), 32'd0);
            check("noto_hold", {29'd0, oib_clk, grant}, 32'h6);
            rq_valid = 2'b10; rq_data = 16'h1200; rq_last = 2'b10;
            #1 check("noto_rdy", 32'(rq_ready), 32'h2);
            tick();
            check("noto_b1", 32'(ob_data), 32'h12);
            rq_valid = 2'b00;
            finish_pkt("noto", 2'b10, -1);
        end
`endif
        rq_valid = 2'b11; rq_last = 2'b11;
        #1 check("after_stall_rdy", 32'(rq_ready), 32'h1);
        tick();
        rq_valid = 2'b00;
        finish_pkt("final", 2'b01, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
